// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam int FZ = 3;
  localparam int FV = 2;
  localparam int FN = 1;
  localparam int FC = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-and-add multiplier: one multiplicand bit per cycle, DSIZE cycles per product.
module alu_mul_iter #(
  parameter int DSIZE = 16,
  parameter int SHW   = $clog2(DSIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [DSIZE-1:0] mcand,
  input  logic [DSIZE-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] product
);

  logic [DSIZE-1:0] mcand_q;
  logic [DSIZE-1:0] mplier_q;
  logic [DSIZE-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic [DSIZE-1:0] addend;
  logic [DSIZE-1:0] acc_nx;

  assign addend  = mcand_q[cnt_q] ? (mplier_q << cnt_q) : '0;
  assign acc_nx  = acc_q + addend;
  // The completing step's partial product is folded in here so the result
  // is ready at the same edge the last step would have been accumulated.
  assign product = acc_nx;
  assign done    = busy && (cnt_q == SHW'(DSIZE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (clear) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= mcand;
      mplier_q <= mplier;
    end else if (busy) begin
      if (done) begin
        busy  <= 1'b0;
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        cnt_q <= cnt_q + SHW'(1);
        acc_q <= acc_nx;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshakes; single-cycle ops finish
// in one edge, MUL runs iteratively in alu_mul_iter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int SHW   = $clog2(DSIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [SHW-1:0]   imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [3:0]       flag
);

  state_t state, state_nx;

  logic             accept;
  logic             single_ld;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_fire;
  logic [DSIZE-1:0] mul_product;

  logic [DSIZE:0]     sum;
  logic [DSIZE-1:0]   diff;
  logic [2*DSIZE-1:0] rot;
  logic [DSIZE-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [DSIZE-1:0]   ld_val;
  logic [3:0]         ld_flag;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign single_ld = accept && (op != OP_MUL);
  assign mul_start = accept && (op == OP_MUL);
  assign mul_fire  = (state == MUL) && mul_done && !flush;

  alu_mul_iter #(.DSIZE(DSIZE), .SHW(SHW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .start   (mul_start),
    .mcand   (a),
    .mplier  (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign rot  = {a, a} << imm;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum[DSIZE-1:0];
        alu_c   = sum[DSIZE];
        alu_v   = (a[DSIZE-1] == b[DSIZE-1]) && (sum[DSIZE-1] != a[DSIZE-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = a < b;
        alu_v   = (a[DSIZE-1] != b[DSIZE-1]) && (diff[DSIZE-1] != a[DSIZE-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << imm;
      OP_SRL:  alu_res = a >> imm;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> imm);
      OP_ROL:  alu_res = rot[2*DSIZE-1:DSIZE];
      OP_SLT:  alu_res = {{(DSIZE-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

  // Accepts only happen in IDLE, so the MUL state alone selects the product.
  assign ld_val        = (state == MUL) ? mul_product : alu_res;
  assign ld_flag[FZ]   = (ld_val == '0);
  assign ld_flag[FV]   = (state == IDLE) && alu_v;
  assign ld_flag[FN]   = ld_val[DSIZE-1];
  assign ld_flag[FC]   = (state == IDLE) && alu_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mul_start) state_nx = MUL;
      MUL:  if (flush || mul_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      flag      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (single_ld || mul_fire) begin
      out_valid <= 1'b1;
      out       <= ld_val;
      flag      <= ld_flag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_state_tracks_mul : assert property (
    @(posedge clk) disable iff (rst) ((state == MUL) == mul_busy)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed self-checking bench for alu_pipe against an
// integer-arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int DSIZE = 16;
  localparam int SHW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [DSIZE-1:0] a, b;
  logic [SHW-1:0]   imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out;
  logic [3:0]       flag;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DSIZE(DSIZE), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag      (flag)
  );

  // Reference: {Z,V,N,C, result} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [3:0] s);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r  = 0;
    logic   v  = 1'b0;
    logic   c  = 1'b0;
    logic [15:0] res;
    case (o)
      4'd0: begin r = ux + uy; c = (r > 65535); v = (sx + sy > 32767) || (sx + sy < -32768); end
      4'd1: begin r = ux - uy; c = (ux < uy);   v = (sx - sy > 32767) || (sx - sy < -32768); end
      4'd2: r = ux & uy;
      4'd3: r = ux | uy;
      4'd4: r = ux << s;
      4'd5: r = ux >> s;
      4'd6: r = sx >>> s;
      4'd7: r = (ux << s) | (ux >> (16 - int'(s)));
      4'd8: r = ux ^ uy;
      4'd9: r = (sx < sy) ? 1 : 0;
      4'd10: r = ux * uy;
      default: r = 0;
    endcase
    res = 16'(r);
    return {res == 16'd0, v, res[15], c, res};
  endfunction

  // Present a request and return #1 after the edge that accepts it.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; imm = s;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0 || flag !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b out=%h flag=%b, want 0/0000/0000", out_valid, out, flag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  logic [3:0]  d_op  [10] = '{OP_ADD, OP_SUB, OP_SUB, OP_ROL, OP_ROL, OP_SRA, OP_SLT, 4'd13, OP_ADD, OP_SUB};
  logic [15:0] d_a   [10] = '{16'h7FFF, 16'h0005, 16'h0001, 16'h8001, 16'h8001, 16'h8000, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h8000};
  logic [15:0] d_b   [10] = '{16'h0001, 16'h0005, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h5678, 16'h0001, 16'h0001};
  logic [3:0]  d_imm [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd15, 4'd0, 4'd3, 4'd0, 4'd0};
  logic [15:0] d_out [10] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0003, 16'h8001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF};
  logic [3:0]  d_flg [10] = '{4'b0110, 4'b1000, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1001, 4'b0100};

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(d_op[i], d_a[i], d_b[i], d_imm[i]);
      vectors++;
      if (out_valid !== 1'b1 || out !== d_out[i] || flag !== d_flg[i]) begin
        miscompares++;
        $display("FAIL directed_%0d: valid=%b out=%h flag=%b, want 1/%h/%b",
                 i, out_valid, out, flag, d_out[i], d_flg[i]);
      end
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    issue(OP_MUL, 16'h0012, 16'h0034, 4'd0);
    // A second request is held for the whole multiply.
    in_valid = 1'b1; op = OP_ADD; a = 16'h0003; b = 16'h0004; imm = 4'd0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_accept: valid=%b in_ready=%b, want 0/0", out_valid, in_ready);
    end
    for (int i = 1; i < DSIZE; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_busy_%0d: valid=%b in_ready=%b, want 0/0", i, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'h03A8 || flag !== 4'b0000) begin
      miscompares++;
      $display("FAIL mul_result: valid=%b out=%h flag=%b, want 1/03a8/0000", out_valid, out, flag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'h0007) begin
      miscompares++;
      $display("FAIL mul_held_req: valid=%b out=%h, want 1/0007", out_valid, out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(OP_ADD, 16'h1234, 16'h1111, 4'd0);
    in_valid = 1'b1; op = OP_XOR; a = 16'hF0F0; b = 16'h0FF0; imm = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out !== 16'h2345 || flag !== 4'b0000 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b out=%h flag=%b in_ready=%b, want 1/2345/0000/0",
                 i, out_valid, out, flag, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'hFF00 || flag !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_replace: valid=%b out=%h flag=%b, want 1/ff00/0010", out_valid, out, flag);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic watch_idle_then_add(input string tag);
    logic seen = 1'b0;
    repeat (DSIZE + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_no_result: out_valid seen=%b want 0", tag, seen);
    end
    issue(OP_ADD, 16'h0001, 16'h0001, 4'd0);
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'h0002 || flag !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s_next_add: valid=%b out=%h flag=%b, want 1/0002/0000", tag, out_valid, out, flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_mid_mul();
    out_ready = 1'b1;
    issue(OP_MUL, 16'h0123, 16'h0045, 4'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    watch_idle_then_add("flush");
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    issue(OP_MUL, 16'h00FF, 16'h0101, 4'd0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0 || flag !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_mid_mul: valid=%b out=%h flag=%b, want 0/0000/0000", out_valid, out, flag);
    end
    @(negedge clk);
    rst = 1'b0;
    watch_idle_then_add("rst");
  endtask

  task automatic test_random();
    logic [3:0]  ro, ri;
    logic [15:0] ra, rb;
    logic [19:0] exp;
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ro  = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      ri  = 4'($urandom_range(0, 15));
      exp = model(ro, ra, rb, ri);
      issue(ro, ra, rb, ri);
      n = 0;
      while (!out_valid && n < DSIZE + 4) begin
        @(posedge clk); #1; n++;
      end
      vectors++;
      if (out_valid !== 1'b1 || out !== exp[15:0] || flag !== exp[19:16]) begin
        miscompares++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h imm=%0d: valid=%b out=%h flag=%b, want 1/%h/%b",
                 k, ro, ra, rb, ri, out_valid, out, flag, exp[15:0], exp[19:16]);
      end
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out !== exp[15:0] || flag !== exp[19:16]) begin
          miscompares++;
          $display("FAIL rand_stall_%0d: valid=%b out=%h flag=%b, want 1/%h/%b",
                   k, out_valid, out, flag, exp[15:0], exp[19:16]);
        end
        out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; imm = '0;
    flush = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_flush_mid_mul();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational EX-stage ALU. It computes the same flag-producing arithmetic, logic and shift ops at any data width, and adds XOR, set-less-than and an iterative multiply. Results are delivered through a registered valid/ready output with backpressure, so the EX stage can stall on a multi-cycle multiply without blocking single-cycle ops elsewhere.

## Interface
- `DSIZE`, 16: operand/result width, ≥ 4.
- `SHW`, `$clog2(DSIZE)`: shift-amount width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted on an edge where `in_valid && in_ready`.
- `op` in 4: operation code (see Operation).
- `a`, `b` in DSIZE: operands.
- `imm` in SHW: shift/rotate amount.
- `flush` in 1: synchronous abort of in-flight work and held result.
- `out_valid` out 1: result held.
- `out_ready` in 1: result consumed on an edge where `out_valid && out_ready`.
- `out` out DSIZE: result.
- `flag` out 4: {Z, V, N, C}.

## Operation
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a−b
  - 2 AND
  - 3 OR
  - 4 SLL a<<imm
  - 5 SRL a>>imm
  - 6 SRA signed a>>>imm
  - 7 ROL rotate-left by imm; imm=0 gives a
  - 8 XOR
  - 9 SLT: 1 if signed a<b, else 0
  - 10 MUL: low DSIZE bits of a*b, unsigned
  - 11–15: out=0, flags Z=1, others 0
- Flags, all computed from the final `out`:
  - Z = (out==0).
  - N = out[DSIZE-1].
  - V = signed overflow, ADD/SUB only, else 0.
  - C = carry-out for ADD; borrow (unsigned a<b) for SUB; 0 otherwise.
  - Flags are independent, not prioritised.
- `in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush`.
- FSM states:
  - IDLE: on accept of op≠10, compute combinationally and load `out`/`flag`/`out_valid` at that edge. On accept of op=10, latch operands, cnt=0, acc=0, go to MUL.
  - MUL: each cycle, if mcand-bit cnt set then acc += mplier<<cnt; cnt++. When cnt==DSIZE-1 at an edge, load out=final acc, flags, out_valid=1, go to IDLE.
- Output register holds value and flags unchanged while `out_valid && !out_ready`.
- Output consumed with no new accept on the same edge: `out_valid` → 0. Consumed with a simultaneous accept: the new result replaces it, `out_valid` stays 1.
- `flush`: state→IDLE, `out_valid`→0, cnt/acc cleared. Takes priority over accept and over MUL completion on the same edge.
- Reset values: `out_valid`=0, `out`=0, `flag`=0, state IDLE, cnt=0, acc=0. `in_ready` is 1 once `rst` deasserts. Reset mid-MUL discards the operation; no result is emitted.

## Timing
- Single-cycle ops: accepted at edge k, so `out_valid` is high after edge k. Latency 1, throughput 1/cycle under `out_ready=1`.
- MUL: accepted at edge k, `out_valid` high after edge k+DSIZE. `in_ready`=0 from k to k+DSIZE inclusive of the completion cycle. Throughput 1 per DSIZE+1 cycles.
- No combinational path from `op`/`a`/`b` to `out`. `in_ready` depends combinationally on `out_ready` and `flush` only.

## Structure
- Package `alu_pkg`:
  - opcode localparams `OP_ADD`…`OP_MUL`
  - flag bit indices `FZ=3, FV=2, FN=1, FC=0`
  - FSM state enum {IDLE, MUL}
- Sub-module `alu_mul_iter`: holds operand registers, counter and accumulator. Ports: start, operands, busy, done, product; clear is driven by `flush`/`rst`.
- Single-cycle datapath and flag logic stay in `alu_pipe`.

## Test plan
- ADD `a=16'h7FFF, b=16'h0001`, `out_ready=1` → `out=16'h8000`, `flag=4'b0110`, `out_valid` one cycle after accept.
- SUB `a=b=16'h0005` → `out=0`, `flag=4'b1000`. SUB `a=16'h0001, b=16'h0002` → `out=16'hFFFF`, `flag=4'b0011`.
- MUL `a=16'h0012, b=16'h0034` → `out=16'h03A8` exactly 16 edges after accept. `in_ready`=0 throughout; a second `in_valid` held during this time is accepted only after completion.
- ROL `a=16'h8001`: imm=1 → `16'h0003`; imm=0 → `16'h8001`. SRA `a=16'h8000`, imm=15 → `16'hFFFF`. SLT `16'hFFFF` vs `16'h0001` → 1.
- Backpressure: `out_ready=0` for 3 cycles after an ADD → `out`/`flag` stable, `in_ready`=0. Raise `out_ready` with a new request present → consumed and replaced on the same edge, `out_valid` stays 1.
- Async `rst` pulse 5 cycles into a MUL, and separately `flush` 5 cycles into a MUL → `out_valid`=0 and no result emitted. Next op ADD 1+1 → `out=2` with latency 1.
